wb_stage: RTL and testbench

//  MEM/WB pipeline register and writeback formatter for the MIPS core; sits directly upstream of regfile.

---
 rtl/mips_pkg.sv | 18 +
 rtl/wb_load_align.sv | 52 +++++
 rtl/wb_stage.sv | 119 +++++++++++
 tb/tb_wb_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, load-size encodings and writeback FSM states.
package mips_pkg;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned CNTW = 16;

   localparam logic [1:0] LDSIZE_WORD = 2'b00;
   localparam logic [1:0] LDSIZE_HALF = 2'b01;
   localparam logic [1:0] LDSIZE_BYTE = 2'b10;

   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StWrite = 2'b01,
      StHeld  = 2'b10
   } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Big-endian load lane select, sign/zero extension and misalignment detection.
module wb_load_align
   import mips_pkg::*;
#(
   parameter int unsigned DataW = DW
) (
   input  logic             memtoreg,
   input  logic [1:0]       ldsize,
   input  logic             ldsigned,
   input  logic [1:0]       addr,
   input  logic [DataW-1:0] aluresult,
   input  logic [DataW-1:0] memdata,
   output logic [DataW-1:0] data,
   output logic             misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = '0;
      half_v     = '0;
      data       = aluresult;
      misaligned = 1'b0;

      // Byte lane 0 is the most significant byte.
      case (addr)
         2'd0:    byte_v = memdata[DataW-1  -: 8];
         2'd1:    byte_v = memdata[DataW-9  -: 8];
         2'd2:    byte_v = memdata[DataW-17 -: 8];
         default: byte_v = memdata[DataW-25 -: 8];
      endcase
      half_v = addr[1] ? memdata[DataW-17 -: 16] : memdata[DataW-1 -: 16];

      if (memtoreg) begin
         case (ldsize)
            LDSIZE_HALF: begin
               data       = {{(DataW-16){ldsigned & half_v[15]}}, half_v};
               misaligned = addr[0];
            end
            LDSIZE_BYTE: begin
               data = {{(DataW-8){ldsigned & byte_v[7]}}, byte_v};
            end
            default: begin
               data       = memdata;
               misaligned = (addr != 2'b00);
            end
         endcase
      end
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and regfile writeback formatter.
// Optional WB_BYPASS_EN adds a combinational forwarding copy of the pending write.
module wb_stage
   import mips_pkg::*;
#(
   parameter int unsigned DataW = DW,
   parameter int unsigned AddrW = AW,
   parameter int unsigned CntW  = CNTW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_regwrite,
   input  logic             in_memtoreg,
   input  logic [1:0]       in_ldsize,
   input  logic             in_ldsigned,
   input  logic [AddrW-1:0] in_dst,
   input  logic [DataW-1:0] in_aluresult,
   input  logic [DataW-1:0] in_memdata,
   input  logic             stall,
   input  logic             flush,
   output logic [AddrW-1:0] a3,
   output logic [DataW-1:0] wr,
   output logic             wrenable,
   output logic             misalign_err,
`ifdef WB_BYPASS_EN
   output logic             byp_valid,
   output logic [AddrW-1:0] byp_dst,
   output logic [DataW-1:0] byp_data,
`endif
   output logic [CntW-1:0]  retired_cnt
);

   wb_state_e        state_q, state_d;
   logic [AddrW-1:0] dst_q, dst_d;
   logic [DataW-1:0] data_q, data_d;
   logic             wen_q, wen_d;
   logic             mis_q, mis_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic             accept;
   logic [DataW-1:0] ld_data;
   logic             ld_mis;

   wb_load_align #(
      .DataW (DataW)
   ) u_load_align (
      .memtoreg   (in_memtoreg),
      .ldsize     (in_ldsize),
      .ldsigned   (in_ldsigned),
      .addr       (in_aluresult[1:0]),
      .aluresult  (in_aluresult),
      .memdata    (in_memdata),
      .data       (ld_data),
      .misaligned (ld_mis)
   );

   assign in_ready = ~stall;
   assign accept   = in_valid & ~stall & ~flush;

   // Strobes only fire in WRITE, so a stalled entry is written exactly once.
   assign wrenable     = (state_q == StWrite) & wen_q;
   assign misalign_err = (state_q == StWrite) & mis_q;
   assign a3           = dst_q;
   assign wr           = data_q;
   assign retired_cnt  = cnt_q;

`ifdef WB_BYPASS_EN
   assign byp_valid = ((state_q == StWrite) | (state_q == StHeld)) & wen_q;
   assign byp_dst   = dst_q;
   assign byp_data  = data_q;
`endif

   always_comb begin
      state_d = state_q;
      dst_d   = dst_q;
      data_d  = data_q;
      wen_d   = wen_q;
      mis_d   = mis_q;
      cnt_d   = cnt_q + CntW'(wrenable);

      if (flush) begin
         state_d = StEmpty;
      end else if (stall) begin
         if (state_q != StEmpty) state_d = StHeld;
      end else if (in_valid) begin
         state_d = StWrite;
      end else begin
         state_d = StEmpty;
      end

      if (accept) begin
         dst_d  = in_dst;
         data_d = ld_data;
         wen_d  = in_regwrite & (in_dst != '0) & ~ld_mis;
         mis_d  = ld_mis;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         dst_q   <= '0;
         data_q  <= '0;
         wen_q   <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         wen_q   <= wen_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage with a small regfile model fed by the write port.
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_regwrite;
   logic        in_memtoreg;
   logic [1:0]  in_ldsize;
   logic        in_ldsigned;
   logic [4:0]  in_dst;
   logic [31:0] in_aluresult;
   logic [31:0] in_memdata;
   logic        stall;
   logic        flush;
   logic [4:0]  a3;
   logic [31:0] wr;
   logic        wrenable;
   logic        misalign_err;
   logic [15:0] retired_cnt;
`ifdef WB_BYPASS_EN
   logic        byp_valid;
   logic [4:0]  byp_dst;
   logic [31:0] byp_data;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] rf [32];

   wb_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_regwrite  (in_regwrite),
      .in_memtoreg  (in_memtoreg),
      .in_ldsize    (in_ldsize),
      .in_ldsigned  (in_ldsigned),
      .in_dst       (in_dst),
      .in_aluresult (in_aluresult),
      .in_memdata   (in_memdata),
      .stall        (stall),
      .flush        (flush),
      .a3           (a3),
      .wr           (wr),
      .wrenable     (wrenable),
      .misalign_err (misalign_err),
`ifdef WB_BYPASS_EN
      .byp_valid    (byp_valid),
      .byp_dst      (byp_dst),
      .byp_data     (byp_data),
`endif
      .retired_cnt  (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
   end
   always @(posedge clk) begin
      if (wrenable) rf[a3] <= wr;
   end

   typedef struct {
      logic        rw;
      logic        mt;
      logic [1:0]  sz;
      logic        sg;
      logic [4:0]  dst;
      logic [31:0] alu;
      logic [31:0] mem;
      logic        ew;
      logic        em;
      logic [31:0] ed;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rw, input logic mt, input logic [1:0] sz, input logic sg,
                        input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] mem);
      in_valid     = 1'b1;
      in_regwrite  = rw;
      in_memtoreg  = mt;
      in_ldsize    = sz;
      in_ldsigned  = sg;
      in_dst       = dst;
      in_aluresult = alu;
      in_memdata   = mem;
   endtask

   initial begin
      int exp_cnt;
      int wen_seen;

      rst_n = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
      in_ldsize = 2'b00; in_ldsigned = 1'b0; in_dst = '0; in_aluresult = '0;
      in_memdata = '0; stall = 1'b0; flush = 1'b0;

      //        rw    mt    sz     sg    dst    alu            mem            ew    em    ed
      vt[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 5'd5,  32'h1234_5678, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
      vt[1]  = '{1'b1, 1'b1, 2'b10, 1'b1, 5'd6,  32'h0000_1001, 32'h11F2_3344, 1'b1, 1'b0, 32'hFFFF_FFF2};
      vt[2]  = '{1'b1, 1'b1, 2'b10, 1'b0, 5'd6,  32'h0000_1001, 32'h11F2_3344, 1'b1, 1'b0, 32'h0000_00F2};
      vt[3]  = '{1'b1, 1'b1, 2'b01, 1'b0, 5'd8,  32'h0000_1002, 32'h11F2_3344, 1'b1, 1'b0, 32'h0000_3344};
      vt[4]  = '{1'b1, 1'b1, 2'b01, 1'b1, 5'd8,  32'h0000_1000, 32'h8001_0000, 1'b1, 1'b0, 32'hFFFF_8001};
      vt[5]  = '{1'b1, 1'b1, 2'b00, 1'b0, 5'd10, 32'h0000_1002, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
      vt[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  32'hAAAA_5555, 32'h0,         1'b0, 1'b0, 32'h0};
      vt[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 5'd11, 32'h5555_AAAA, 32'h0,         1'b0, 1'b0, 32'h0};
      vt[8]  = '{1'b1, 1'b1, 2'b10, 1'b1, 5'd12, 32'h0000_2003, 32'h0000_00A5, 1'b1, 1'b0, 32'hFFFF_FFA5};
      vt[9]  = '{1'b1, 1'b1, 2'b11, 1'b1, 5'd13, 32'h0000_2000, 32'h8765_4321, 1'b1, 1'b0, 32'h8765_4321};
      vt[10] = '{1'b1, 1'b1, 2'b01, 1'b0, 5'd14, 32'h0000_2001, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
      vt[11] = '{1'b1, 1'b1, 2'b10, 1'b1, 5'd15, 32'h0000_2000, 32'h7F00_0000, 1'b1, 1'b0, 32'h0000_007F};

      #12;
      chk("reset_a3", {27'b0, a3}, 32'h0);
      chk("reset_wr", wr, 32'h0);
      chk("reset_wrenable", {31'b0, wrenable}, 32'h0);
      chk("reset_misalign", {31'b0, misalign_err}, 32'h0);
      chk("reset_cnt", {16'b0, retired_cnt}, 32'h0);
      rst_n = 1'b1;
      step();

      // Back-to-back retirements, one per cycle.
      exp_cnt = 0;
      foreach (vt[i]) begin
         drive(vt[i].rw, vt[i].mt, vt[i].sz, vt[i].sg, vt[i].dst, vt[i].alu, vt[i].mem);
         step();
         chk($sformatf("vec%0d_wrenable", i), {31'b0, wrenable}, {31'b0, vt[i].ew});
         chk($sformatf("vec%0d_misalign", i), {31'b0, misalign_err}, {31'b0, vt[i].em});
         chk($sformatf("vec%0d_a3", i), {27'b0, a3}, {27'b0, vt[i].dst});
         if (vt[i].ew) chk($sformatf("vec%0d_wr", i), wr, vt[i].ed);
         if (vt[i].ew) exp_cnt++;
      end
      in_valid = 1'b0;
      step();
      chk("table_idle_wrenable", {31'b0, wrenable}, 32'h0);
      chk("table_cnt", {16'b0, retired_cnt}, exp_cnt[31:0]);
      chk("rf_reg5", rf[5], 32'h1234_5678);
      chk("rf_reg0", rf[0], 32'h0);

      // Accept then stall three cycles: exactly one write strobe.
      drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd9, 32'hCAFE_BABE, 32'h0);
      step();
      in_valid = 1'b0;
      stall = 1'b1;
      chk("stall_ready", {31'b0, in_ready}, 32'h0);
      wen_seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 3) stall = 1'b0;
         if (wrenable) wen_seen++;
         chk($sformatf("stall%0d_a3", c), {27'b0, a3}, 32'd9);
         chk($sformatf("stall%0d_wr", c), wr, 32'hCAFE_BABE);
`ifdef WB_BYPASS_EN
         if (c < 4) chk($sformatf("stall%0d_byp_valid", c), {31'b0, byp_valid}, 32'h1);
         if (c < 4) chk($sformatf("stall%0d_byp_data", c), byp_data, 32'hCAFE_BABE);
`endif
         step();
      end
      chk("stall_wen_pulses", wen_seen[31:0], 32'd1);
      exp_cnt++;
      chk("stall_cnt", {16'b0, retired_cnt}, exp_cnt[31:0]);

      // Flush while HELD, with a new instruction presented: nothing is written.
      drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd16, 32'h0BAD_F00D, 32'h0);
      step();
      in_valid = 1'b0;
      stall = 1'b1;
      step();
      chk("held_wrenable", {31'b0, wrenable}, 32'h0);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd17, 32'h1111_2222, 32'h0);
      flush = 1'b1;
      step();
      chk("flush_wrenable", {31'b0, wrenable}, 32'h0);
      chk("flush_a3", {27'b0, a3}, 32'd16);
`ifdef WB_BYPASS_EN
      chk("flush_byp_valid", {31'b0, byp_valid}, 32'h0);
`endif
      flush = 1'b0;
      stall = 1'b0;
      in_valid = 1'b0;
      step();
      chk("post_flush_wrenable", {31'b0, wrenable}, 32'h0);
      exp_cnt++;
      chk("flush_cnt", {16'b0, retired_cnt}, exp_cnt[31:0]);
      chk("rf_reg17", rf[17], 32'h0);

      // Asynchronous reset while a load is in WRITE.
      drive(1'b1, 1'b1, 2'b00, 1'b0, 5'd7, 32'h0000_3000, 32'h7777_7777);
      step();
      chk("pre_reset_wrenable", {31'b0, wrenable}, 32'h1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midreset_wrenable", {31'b0, wrenable}, 32'h0);
      chk("midreset_cnt", {16'b0, retired_cnt}, 32'h0);
      step();
      rst_n = 1'b1;
      chk("midreset_rf_reg7", rf[7], 32'h0);
      step();
      chk("after_reset_wrenable", {31'b0, wrenable}, 32'h0);

      // Counter wrap: 0xFFFF writes then one more.
      drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd1, 32'h0000_0001, 32'h0);
      repeat (65535) step();
      in_valid = 1'b0;
      step();
      chk("cnt_max", {16'b0, retired_cnt}, 32'h0000_FFFF);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd2, 32'h0000_0002, 32'h0);
      step();
      chk("wrap_wrenable", {31'b0, wrenable}, 32'h1);
      in_valid = 1'b0;
      step();
      chk("cnt_wrap", {16'b0, retired_cnt}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
